// File: rtl/shmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency memory among NUM_MASTERS Avalon-MM masters.
// Define SHMEM_ARB_LOCK_EN to add m_lock, which pins arbitration to one master for atomic sequences.
module shmem_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int BE_W        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
`ifdef SHMEM_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]        m_lock,
`endif
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [BE_W-1:0]               mem_byteenable,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic                          mem_clken,
    input  logic [DATA_W-1:0]             mem_readdata
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick;
    logic             pick_valid;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] req_eff;
    logic [ADDR_W-1:0]      addr_a [NUM_MASTERS];
    logic [BE_W-1:0]        be_a   [NUM_MASTERS];
    logic [DATA_W-1:0]      wd_a   [NUM_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign req[gi]    = m_read[gi] | m_write[gi];
            assign addr_a[gi] = m_address[gi*ADDR_W +: ADDR_W];
            assign be_a[gi]   = m_byteenable[gi*BE_W +: BE_W];
            assign wd_a[gi]   = m_writedata[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef SHMEM_ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    // While locked only the owner may win; last_q equals the owner so the scan lands on it.
    always_comb begin
        req_eff = req;
        if (lock_q) begin
            req_eff          = '0;
            req_eff[owner_q] = req[owner_q];
        end
    end
`else
    assign req_eff = req;
`endif

    // First requester after last_q, wrapping modulo NUM_MASTERS.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_MASTERS);
            if (!pick_valid && req_eff[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        m_waitrequest   = '1;
        m_readdatavalid = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_byteenable  = '0;
        mem_writedata   = '0;
`ifdef SHMEM_ARB_LOCK_EN
        lock_d          = lock_q;
        owner_d         = owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = ISSUE;
                end
`ifdef SHMEM_ARB_LOCK_EN
                if (lock_q && !req[owner_q]) begin
                    lock_d = 1'b0;
                end
`endif
            end
            ISSUE: begin
                // A master that withdrew its request still gets waitrequest low, but no memory cycle.
                mem_chipselect         = req[grant_q];
                mem_write              = m_write[grant_q];
                mem_address            = addr_a[grant_q];
                mem_byteenable         = be_a[grant_q];
                mem_writedata          = wd_a[grant_q];
                m_waitrequest[grant_q] = 1'b0;
                last_d                 = grant_q;
                state_d                = (m_read[grant_q] && !m_write[grant_q]) ? RDATA : IDLE;
`ifdef SHMEM_ARB_LOCK_EN
                if (req[grant_q]) begin
                    lock_d  = m_lock[grant_q];
                    owner_d = grant_q;
                end
`endif
            end
            RDATA: begin
                m_readdatavalid[grant_q] = 1'b1;
                state_d                  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_readdata = mem_readdata;
    assign mem_clken  = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
`ifdef SHMEM_ARB_LOCK_EN
            lock_q  <= 1'b0;
            owner_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef SHMEM_ARB_LOCK_EN
            lock_q  <= lock_d;
            owner_q <= owner_d;
`endif
        end
    end

endmodule
